tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
- Receive-side counterpart of the team's 2:1 mux: recovers NCH parallel channels from one time-division-multiplexed serial bit stream.
- The stream is framed by a sync pulse. Each frame is NCH slots of W bits each.
- Sits after the serial link. Presents each complete frame as one parallel word with a one-cycle valid pulse, and flags framing errors.

Parameters:
- NCH, 4, number of channels (slots) per frame, >=2.
- W, 8, bits per channel slot, >=2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  bit strobe; din and fsync are sampled only on rising edges where en=1.
- din  input  1  serial TDM data.
- fsync  input  1  frame sync; high together with en on bit 0 of every frame.
- y  output  NCH*W  last complete frame; channel k at y[k*W +: W].
- valid  output  1  one-cycle pulse when y is updated.
- sel  output  clog2(NCH)  channel slot currently being received.
- locked  output  1  high while in RUN.
- sync_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - y=0, valid=0, sel=0, locked=0, sync_err=0.
  - State HUNT; bit counter=0; shift and staging registers cleared.
  - Deassertion takes effect on the next rising edge.
  - Reset mid-frame discards the partial frame.
- Sampling:
  - Edges with en=0 change nothing except clearing any valid/sync_err pulse raised on the previous edge.
  - fsync with en=0 is ignored.
- Frame layout:
  - Frame bit index b runs 0..NCH*W-1; slot = b/W, bit within slot = b%W.
  - Each slot is sent MSB first: the first bit of slot k lands in y[k*W+W-1].
- State machine:
  - HUNT, edge with en=1, fsync=0: bit discarded; stay in HUNT.
  - HUNT, edge with en=1, fsync=1: bit taken as frame bit 0. Go to RUN; counter=1; locked=1 from the next cycle.
  - RUN, edge with en=1, counter != 0, fsync=0: shift in din; counter increments.
    - At slot end (b%W = W-1): the slot word is written to staging slot sel, then sel increments.
  - RUN, last bit (b = NCH*W-1):
    - The final slot word and all staging go to y on the same edge; valid=1 for exactly one cycle.
    - Counter wraps to 0; sel wraps to 0.
  - RUN, counter=0, fsync=1: normal frame start; continue as bit 0.
  - RUN, counter=0, fsync=0 (missing sync):
    - sync_err pulse; go to HUNT; locked=0; bit discarded; y held.
  - RUN, counter != 0, fsync=1 (early sync):
    - sync_err pulse; partial frame discarded; y held.
    - The sampled bit is frame bit 0 of a new frame; counter=1; stay in RUN.
- Output timing:
  - y, valid and sync_err are registered: visible the cycle after the sampling edge.
  - y holds its value until the next complete frame.
  - valid and sync_err are never both high.
- Latency: valid and y are visible one clk after the edge that samples the last bit of the frame.
- Back-to-back frames need no idle bits. Gaps in en of any length are allowed anywhere.

Test Plan:
- Reset, then one frame (NCH=4, W=8) with fsync on bit 0 and slots 0xA5, 0x3C, 0xFF, 0x01 -> y=32'h01FF3CA5. valid high exactly one cycle after the 32nd en edge. locked=1, sync_err=0 throughout.
- Same frame with en low for 3 cycles between random bits -> identical y and a single valid pulse. sel steps 0,1,2,3 at slot boundaries.
- Two back-to-back frames (second with slots 0x11, 0x22, 0x33, 0x44), fsync on each bit 0 -> two valid pulses 32 en edges apart. Final y=32'h44332211.
- Locked, then fsync at bit 10 -> sync_err one cycle, no valid, y still 32'h01FF3CA5. The next 32 bits form a new frame that completes normally.
- Locked, fsync absent at the next frame start -> sync_err pulse, locked=0. Bits are ignored until the next fsync; y held.
- Assert rst_n=0 at bit 17 of a frame -> y=0, locked=0, sel=0 immediately. After release, a full frame with fsync decodes correctly.

Source files
------------

// File: rtl/tdm_demux.sv
// -----------------------------------------------------------------------------
// tdm_demux
//
// Receive-side TDM demultiplexer. Recovers NCH parallel channels of W bits
// each from a serial bit stream framed by a sync pulse. Each frame is NCH
// slots sent back to back, and each slot is sent MSB first. When a frame is
// complete it is presented on y with a one-cycle valid pulse. Framing errors
// produce a one-cycle sync_err pulse.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   en       bit strobe; din/fsync are sampled only when en=1
//   din      serial TDM data
//   fsync    frame sync, high with en on bit 0 of every frame
//   y        last complete frame, channel k at y[k*W +: W]
//   valid    one-cycle pulse when y is updated
//   sel      channel slot currently being received
//   locked   high while frame-locked (RUN)
//   sync_err one-cycle pulse on a framing error (missing or early sync)
// -----------------------------------------------------------------------------
module tdm_demux #(
  parameter int NCH = 4,
  parameter int W   = 8,
  localparam int SW = $clog2(NCH),
  localparam int BW = $clog2(W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              din,
  input  logic              fsync,
  output logic [NCH*W-1:0]  y,
  output logic              valid,
  output logic [SW-1:0]     sel,
  output logic              locked,
  output logic              sync_err
);

  typedef enum logic {HUNT, RUN} state_t;

  state_t             state;
  logic [BW-1:0]      bcnt;    // bit position within the current slot
  logic [W-2:0]       shift;   // bits of the current slot received so far
  logic [NCH*W-1:0]   stage;   // completed slots of the frame in progress
  logic [W-1:0]       word;    // current slot including the bit being sampled
  logic [NCH*W-1:0]   frame;   // staging with the final slot merged in
  logic               frame_start;
  logic               slot_end;
  logic               last_slot;

  // The frame bit counter is sel*W + bcnt, so it is zero exactly when both
  // parts are zero; that is the only position where fsync is expected.
  assign word        = {shift, din};
  assign frame_start = (bcnt == '0) && (sel == '0);
  assign slot_end    = (bcnt == BW'(W - 1));
  assign last_slot   = (sel == SW'(NCH - 1));

  // NOTE: every variable assigned in a combinational block gets a full
  // default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    frame = stage;
    frame[(NCH-1)*W +: W] = word;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      bcnt     <= '0;
      sel      <= '0;
      shift    <= '0;
      // NOTE: the staging register is a plain flop array (not a RAM), so it
      // is cleared on reset along with everything else; a partial frame cut
      // by reset must never leak into a later y.
      stage    <= '0;
      y        <= '0;
      valid    <= 1'b0;
      locked   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      // Pulses last exactly one cycle, including across en=0 edges.
      valid    <= 1'b0;
      sync_err <= 1'b0;

      if (en) begin
        unique case (state)
          HUNT: begin
            // Bits are discarded until a sync marks frame bit 0.
            if (fsync) begin
              state  <= RUN;
              locked <= 1'b1;
              shift  <= word[W-2:0];
              bcnt   <= BW'(1);
              sel    <= '0;
            end
          end

          RUN: begin
            if (frame_start && !fsync) begin
              // Missing sync: drop lock, discard the bit, keep y.
              sync_err <= 1'b1;
              state    <= HUNT;
              locked   <= 1'b0;
            end else if (!frame_start && fsync) begin
              // Early sync: abandon the partial frame and restart on this
              // bit as frame bit 0. Stale staging slots are all rewritten
              // before the next frame reaches y.
              sync_err <= 1'b1;
              shift    <= word[W-2:0];
              bcnt     <= BW'(1);
              sel      <= '0;
            end else begin
              shift <= word[W-2:0];
              if (slot_end) begin
                bcnt <= '0;
                stage[sel*W +: W] <= word;
                if (last_slot) begin
                  y     <= frame;
                  valid <= 1'b1;
                  sel   <= '0;
                end else begin
                  sel <= sel + 1'b1;
                end
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end
          end

          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux
//
// Self-checking bench for tdm_demux. A driver issues sampled bits and feeds a
// bit-stream reference model, which pushes expected frame/error events into a
// scoreboard queue tagged with the cycle they must appear on. A monitor,
// sampling 1 time unit after each rising edge, pops and compares events and
// also checks y/locked/sel against the model every cycle.
// -----------------------------------------------------------------------------
module tb_tdm_demux;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int FW  = NCH * W;
  localparam int SW  = $clog2(NCH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          din = 1'b0;
  logic          fsync = 1'b0;
  logic [FW-1:0] y;
  logic          valid;
  logic [SW-1:0] sel;
  logic          locked;
  logic          sync_err;

  tdm_demux #(.NCH(NCH), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .din      (din),
    .fsync    (fsync),
    .y        (y),
    .valid    (valid),
    .sel      (sel),
    .locked   (locked),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a queue of frame bits received since the last frame start.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit            is_err;
    logic [FW-1:0] data;
    int            at_cyc;
  } ev_t;

  ev_t           sbq[$];
  bit            m_locked;
  bit            fbits[$];
  logic [FW-1:0] m_y;

  function automatic int m_sel();
    return m_locked ? fbits.size() / W : 0;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    fbits.delete();
    m_y = '0;
    sbq.delete();
  endtask

  task automatic push_ev(input bit is_err, input int at);
    ev_t e;
    e.is_err = is_err;
    e.data   = m_y;
    e.at_cyc = at;
    sbq.push_back(e);
  endtask

  task automatic model_step(input bit b, input bit fs, input int at);
    if (!m_locked) begin
      if (fs) begin
        m_locked = 1'b1;
        fbits = {b};
      end
    end else if (fs && fbits.size() != 0) begin
      push_ev(1'b1, at);
      fbits = {b};
    end else if (!fs && fbits.size() == 0) begin
      push_ev(1'b1, at);
      m_locked = 1'b0;
    end else begin
      fbits.push_back(b);
      if (fbits.size() == FW) begin
        // Slot k's first-received bit is its MSB.
        for (int k = 0; k < NCH; k++)
          for (int i = 0; i < W; i++)
            m_y[k*W + W-1-i] = fbits[k*W + i];
        push_ev(1'b0, at);
        fbits.delete();
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic drive_bit(input bit b, input bit fs);
    @(negedge clk);
    en    = 1'b1;
    din   = b;
    fsync = fs;
    model_step(b, fs, cyc + 1);
  endtask

  // en low with random din/fsync: nothing may be sampled.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en    = 1'b0;
      din   = 1'($urandom);
      fsync = 1'($urandom);
    end
  endtask

  task automatic send_frame(input logic [FW-1:0] f, input int nbits,
                            input bit sync, input int gap_pct);
    logic [FW-1:0] fv;
    fv = f;
    for (int i = 0; i < nbits; i++) begin
      drive_bit(fv[(i / W) * W + W-1 - (i % W)], sync && (i == 0));
      if (int'($urandom_range(99)) < gap_pct) idle(3);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin : monitor
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      check(!(valid && sync_err), "valid_and_sync_err", {valid, sync_err}, 2'b00);
      if (sbq.size() > 0 && sbq[0].at_cyc == cyc) begin
        e = sbq.pop_front();
        check(valid == !e.is_err && sync_err == e.is_err, "pulse_kind",
              {valid, sync_err}, {!e.is_err, e.is_err});
        check(y == e.data, "pulse_y", y, e.data);
      end else begin
        check(!valid && !sync_err, "spurious_pulse", {valid, sync_err}, 2'b00);
      end
      check(y == m_y && locked == m_locked && sel == m_sel(), "state_lock_sel_y",
            {locked, sel, y}, {m_locked, SW'(m_sel()), m_y});
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 200000", cyc);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    int mode;
    logic [FW-1:0] f;

    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single clean frame.
    send_frame(32'h01FF3CA5, FW, 1'b1, 0);
    idle(2);
    check(y == 32'h01FF3CA5, "frame1_y", y, 32'h01FF3CA5);

    // Same frame with en gaps between bits.
    send_frame(32'h01FF3CA5, FW, 1'b1, 30);
    idle(2);
    check(y == 32'h01FF3CA5, "gapped_frame_y", y, 32'h01FF3CA5);

    // Early sync at bit 10, then a full frame starting on that sync bit.
    send_frame(32'hDEADBEEF, 10, 1'b1, 0);
    send_frame(32'h12345678, FW, 1'b1, 0);
    idle(2);
    check(y == 32'h12345678, "after_early_sync_y", y, 32'h12345678);

    // Back-to-back frames with no idle bits.
    send_frame(32'h01FF3CA5, FW, 1'b1, 0);
    send_frame(32'h44332211, FW, 1'b1, 0);
    idle(2);
    check(y == 32'h44332211, "back_to_back_y", y, 32'h44332211);

    // Missing sync at the next frame start: unlock, ignore bits, hold y.
    send_frame(32'hCAFEF00D, FW, 1'b0, 0);
    idle(2);
    check(locked == 1'b0, "missing_sync_unlocked", locked, 1'b0);
    check(y == 32'h44332211, "missing_sync_y_held", y, 32'h44332211);
    send_frame(32'h5A5AA5A5, FW, 1'b1, 10);
    idle(2);
    check(y == 32'h5A5AA5A5, "relock_y", y, 32'h5A5AA5A5);

    // Reset in the middle of a frame (after bit 16, i.e. at bit 17).
    send_frame(32'h0F0F0F0F, 17, 1'b1, 0);
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check(y == '0 && locked == 1'b0 && sel == '0, "async_reset_outputs",
          {locked, sel, y}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_frame(32'h89ABCDEF, FW, 1'b1, 0);
    idle(2);
    check(y == 32'h89ABCDEF, "post_reset_y", y, 32'h89ABCDEF);

    // Random frames with occasional missing/early syncs and en gaps.
    for (int r = 0; r < 16; r++) begin
      f = FW'($urandom);
      mode = int'($urandom_range(9));
      if (mode == 0)
        send_frame(f, FW, 1'b0, 20);
      else if (mode == 1)
        send_frame(f, int'($urandom_range(FW - 1, 1)), 1'b1, 20);
      else
        send_frame(f, FW, 1'b1, 20);
    end
    idle(5);
    check(sbq.size() == 0, "scoreboard_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
